// File: rtl/mcu0_pkg.sv
// Shared types and constants for the mcu0 byte-memory arbiter.
package mcu0_pkg;

  localparam int unsigned AW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mcu0_arb_pick.sv
// Grant selection between fetch and data ports; on a tie the requester other than last_own wins.
module mcu0_arb_pick
  import mcu0_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_own,
  output owner_t winner
);

  always_comb begin
    winner = OWN_D;
    if (i_req && d_req) begin
      winner = (last_own == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end

endmodule

// File: rtl/mcu0_mem_arb.sv
// Arbitrates 16-bit fetch/data word accesses onto an 8-bit memory, high byte first.
// Define MCU0_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mcu0_mem_arb
  import mcu0_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [15:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [15:0]   d_wdata,
  output logic          d_ack,
  output logic [15:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  state_t        state_q, state_d;
  owner_t        own_q, own_d;
  owner_t        winner, last_own;
  logic          we_q, we_d;
  logic [7:0]    wlo_q, wlo_d;
  logic [7:0]    rhi_q, rhi_d;
  logic [7:0]    rlo_q, rlo_d;
  logic          mem_en_d, mem_we_d, i_ack_d, d_ack_d, busy_d;
  logic [AW-1:0] mem_addr_d;
  logic [7:0]    mem_wdata_d;

  mcu0_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_own (last_own),
    .winner   (winner)
  );

`ifdef MCU0_ARB_RR_EN
  owner_t rr_ptr;  // requester favoured on the next tie

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= OWN_D;
    end else if (state_q == IDLE && (i_req || d_req)) begin
      rr_ptr <= (winner == OWN_D) ? OWN_I : OWN_D;
    end
  end

  assign last_own = (rr_ptr == OWN_D) ? OWN_I : OWN_D;
`else
  assign last_own = OWN_I;
`endif

  // Low read byte arrives during DONE, so it is forwarded straight from memory on the ack cycle.
  assign i_rdata = {rhi_q, (state_q == DONE) ? mem_rdata : rlo_q};
  assign d_rdata = i_rdata;

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    wlo_d       = wlo_q;
    rhi_d       = rhi_q;
    rlo_d       = rlo_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d     = HI;
          own_d       = winner;
          we_d        = (winner == OWN_D) && d_we;
          wlo_d       = (winner == OWN_D) ? d_wdata[7:0] : 8'h00;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = (winner == OWN_D) ? d_addr : i_addr;
          mem_wdata_d = (winner == OWN_D) ? d_wdata[15:8] : 8'h00;
        end
      end
      HI: begin
        state_d     = LO;
        mem_en_d    = 1'b1;
        mem_we_d    = we_q;
        mem_addr_d  = mem_addr + AW'(1);
        mem_wdata_d = wlo_q;
      end
      LO: begin
        state_d = DONE;
        if (!we_q) rhi_d = mem_rdata;
        i_ack_d = (own_q == OWN_I);
        d_ack_d = (own_q == OWN_D);
      end
      DONE: begin
        state_d = IDLE;
        if (!we_q) rlo_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      own_q     <= OWN_D;
      we_q      <= 1'b0;
      wlo_q     <= 8'h00;
      rhi_q     <= 8'h00;
      rlo_q     <= 8'h00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      we_q      <= we_d;
      wlo_q     <= wlo_d;
      rhi_q     <= rhi_d;
      rlo_q     <= rlo_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mcu0_mem_arb.sv
// Bench for mcu0_mem_arb: byte memory, transaction-level reference model, directed and random traffic.
module tb_mcu0_mem_arb;

  localparam int unsigned AW = 12;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [15:0]   i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [15:0]   d_wdata = '0;
  logic          d_ack;
  logic [15:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mcu0_mem_arb #(.AW(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte memory seen by the DUT, with a preload port for the bench
  logic [7:0]    mem [4096] = '{default: 8'h00};
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [7:0]    pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model: a transaction occupies the three cycles after its grant edge
  logic [7:0]    ref_mem [4096] = '{default: 8'h00};
  int            cyc, g_cyc, m_off;
  bit            t_d, t_we, m_last, m_wd;
  logic [AW-1:0] t_a, t_a1;
  logic [15:0]   t_wd, t_rd;
  bit            e_busy, e_en, e_we, e_iack, e_dack;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_wdata;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g_cyc = -100; cyc = 0; m_last = 1'b0;
      e_busy = 0; e_en = 0; e_we = 0; e_iack = 0; e_dack = 0;
      e_addr = '0; e_wdata = '0;
    end else begin
      if (pl_en) ref_mem[pl_addr] = pl_data;
      m_off = cyc - g_cyc;
      if (t_we && m_off == 0) ref_mem[t_a] = t_wd[15:8];
      if (t_we && m_off == 1) ref_mem[t_a1] = t_wd[7:0];
      cyc++;
      if (m_off >= 3 && (i_req || d_req)) begin
`ifdef MCU0_ARB_RR_EN
        m_wd = (i_req && d_req) ? !m_last : d_req;
`else
        m_wd = d_req;
`endif
        t_d    = m_wd;
        t_we   = m_wd && d_we;
        t_a    = m_wd ? d_addr : i_addr;
        t_a1   = t_a + 12'd1;
        t_wd   = m_wd ? d_wdata : 16'h0000;
        t_rd   = {ref_mem[t_a], ref_mem[t_a1]};
        g_cyc  = cyc;
        m_last = m_wd;
      end
      m_off   = cyc - g_cyc;
      e_busy  = (m_off <= 2);
      e_en    = (m_off <= 1);
      e_we    = e_en && t_we;
      e_addr  = (m_off == 0) ? t_a : t_a1;
      e_wdata = (m_off == 0) ? t_wd[15:8] : t_wd[7:0];
      e_iack  = (m_off == 2) && !t_d;
      e_dack  = (m_off == 2) && t_d;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (reset_n) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("i_ack", 32'(i_ack), 32'(e_iack));
      chk("d_ack", 32'(d_ack), 32'(e_dack));
      if (e_en) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      if (e_iack && !t_we) chk("i_rdata", 32'(i_rdata), 32'(t_rd));
      if (e_dack && !t_we) chk("d_rdata", 32'(d_rdata), 32'(t_rd));
    end
  end

  // Traces for the directed checks
  logic [AW-1:0] trace[$];
  bit            aq[$];
  always @(negedge clock) begin
    if (reset_n && mem_en) trace.push_back(mem_addr);
    if (reset_n && d_ack) aq.push_back(1'b1);
    if (reset_n && i_ack) aq.push_back(1'b0);
  end

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Issue one request (called just after a negedge) and hold it until its ack
  task automatic do_req(input bit is_d, input bit we, input logic [AW-1:0] a,
                        input logic [15:0] wd, input int bound,
                        output logic [15:0] rd, output int lat);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    lat = 0;
    rd  = 16'h0000;
    while (1) begin
      @(negedge clock);
      lat++;
      if (is_d ? d_ack : i_ack) begin
        rd = is_d ? d_rdata : i_rdata;
        break;
      end
      if (lat >= bound) begin
        checks++; errors++;
        $display("FAIL ack_timeout: port %0d addr %0h no ack after %0d cycles", is_d, a, lat);
        break;
      end
    end
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int lat, nmis;
    bit exp_own;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;

    // Contention straight after reset
    @(negedge clock);
    aq.delete();
    i_req = 1'b1; i_addr = 12'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h200;
    repeat (16) @(negedge clock);
    i_req = 1'b0; d_req = 1'b0;
    chk("contend_count", 32'(aq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef MCU0_ARB_RR_EN
      exp_own = (k % 2 == 0);
`else
      exp_own = 1'b1;
`endif
      chk("contend_owner", 32'(aq.size() > k ? aq[k] : 1'bx), 32'(exp_own));
    end

    // Fetch read
    preload(12'h010, 8'h12);
    preload(12'h011, 8'h34);
    trace.delete();
    do_req(1'b0, 1'b0, 12'h010, 16'h0000, 20, rd, lat);
    chk("fetch_rdata", 32'(rd), 32'h1234);
    chk("fetch_latency", 32'(lat), 32'd3);
    chk("fetch_trace_n", 32'(trace.size()), 32'd2);
    chk("fetch_trace0", 32'(trace.size() > 0 ? trace[0] : 12'hx), 32'h010);
    chk("fetch_trace1", 32'(trace.size() > 1 ? trace[1] : 12'hx), 32'h011);

    // Data write
    @(negedge clock);
    do_req(1'b1, 1'b1, 12'h020, 16'hBEEF, 20, rd, lat);
    chk("write_latency", 32'(lat), 32'd3);
    chk("write_hi", 32'(mem[12'h020]), 32'hBE);
    chk("write_lo", 32'(mem[12'h021]), 32'hEF);

    // Address wrap
    @(negedge clock);
    preload(12'hFFF, 8'hAA);
    preload(12'h000, 8'h55);
    trace.delete();
    do_req(1'b1, 1'b0, 12'hFFF, 16'h0000, 20, rd, lat);
    chk("wrap_rdata", 32'(rd), 32'hAA55);
    chk("wrap_trace1", 32'(trace.size() > 1 ? trace[1] : 12'hx), 32'h000);

    // Reset during the low byte of a write
    @(negedge clock);
    preload(12'h031, 8'h77);
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h030; d_wdata = 16'h1234;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_d_ack", 32'(d_ack), 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    chk("abort_hi_kept", 32'(mem[12'h030]), 32'h12);
    chk("abort_lo_untouched", 32'(mem[12'h031]), 32'h77);
    @(negedge clock);
    do_req(1'b1, 1'b0, 12'h030, 16'h0000, 20, rd, lat);
    chk("after_abort_rdata", 32'(rd), 32'h1277);
    chk("after_abort_latency", 32'(lat), 32'd3);

    // Random concurrent traffic
    @(negedge clock);
    fork
      begin
        logic [15:0] r; int l;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_req(1'b0, 1'b0, 12'($urandom), 16'h0000, 300, r, l);
        end
      end
      begin
        logic [15:0] r; int l;
        logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 4)) @(negedge clock);
          a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 63));
          do_req(1'b1, 1'($urandom), a, 16'($urandom), 300, r, l);
        end
      end
    join

    repeat (4) @(negedge clock);
    nmis = 0;
    for (int k = 0; k < 4096; k++) if (mem[k] !== ref_mem[k]) nmis++;
    chk("mem_image", 32'(nmis), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu0_mem_arb.md
MCU0_MEM_ARB -- requirements
Module: mcu0_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 12, meaning the byte-address width (matches the 12-bit instruction constant field).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_req, input, 1, instruction-fetch request (read only).
REQ-005 SHALL have port i_addr, input, AW, fetch word address (byte address of the high byte).
REQ-006 SHALL have port i_ack, output, 1, one-cycle fetch-complete pulse.
REQ-007 SHALL have port i_rdata, output, 16, fetched word, valid when i_ack=1.
REQ-008 SHALL have port d_req, input, 1, data-access request.
REQ-009 SHALL have port d_we, input, 1, data write (1) or read (0).
REQ-010 SHALL have port d_addr, input, AW, data word address.
REQ-011 SHALL have port d_wdata, input, 16, data write word.
REQ-012 SHALL have port d_ack, output, 1, one-cycle data-complete pulse.
REQ-013 SHALL have port d_rdata, output, 16, read word, valid when d_ack=1 and d_we was 0.
REQ-014 SHALL have port mem_en, output, 1, byte-memory access strobe.
REQ-015 SHALL have port mem_we, output, 1, byte write enable, qualified by mem_en.
REQ-016 SHALL have port mem_addr, output, AW, byte address.
REQ-017 SHALL have port mem_wdata, output, 8, byte write data.
REQ-018 SHALL have port mem_rdata, input, 8, byte read data, valid the cycle after mem_en with mem_we=0.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> HI -> LO -> DONE -> IDLE; IDLE -> HI only when a request is granted, otherwise stay IDLE.
REQ-021 SHALL latch the winner, address, we and wdata on the IDLE->HI edge; later input changes SHALL have no effect on the transaction.
REQ-022 HI: mem_en=1, mem_addr=a, mem_we=we, mem_wdata=wdata[15:8] (big-endian, high byte first).
REQ-023 LO: mem_en=1, mem_addr=(a+1) mod 2^AW, mem_we=we, mem_wdata=wdata[7:0]; on reads SHALL capture mem_rdata into rdata[15:8].
REQ-024 DONE: mem_en=0; on reads SHALL capture mem_rdata into rdata[7:0]; winner's ack=1 with rdata valid in that cycle.
REQ-025 Latency: request sampled at edge k -> ack high in cycle k+3, exactly one cycle.
REQ-026 Requester SHALL hold req and operands until ack; a req still high in the DONE cycle SHALL be re-arbitrated in IDLE of the following cycle (back-to-back spacing 4 cycles).
REQ-027 Default priority: d_req beats i_req when both high in IDLE.
REQ-028 Never both acks high; mem_en=0 in IDLE and DONE.
REQ-029 Address 0xFFF (AW=12) SHALL wrap the low byte to 0x000.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, mem_en=0, mem_we=0, i_ack=0, d_ack=0, busy=0, rdata registers=0, RR pointer=data.
REQ-031 Reset in HI/LO SHALL abort without ack; a high byte already written SHALL stay written (no rollback).

Configuration
REQ-032 With MCU0_ARB_RR_EN defined SHALL use round-robin: on simultaneous requests the requester not granted last wins; pointer updates on each grant.
REQ-033 Without MCU0_ARB_RR_EN SHALL use fixed data-over-fetch priority (REQ-027) and contain no pointer flop.

Structure
REQ-034 Package mcu0_pkg SHALL hold the FSM state enum (IDLE/HI/LO/DONE), the owner enum (OWN_I/OWN_D) and the default AW constant.
REQ-035 Grant selection SHALL be one sub-module, mcu0_arb_pick (inputs i_req, d_req, last owner; output winner).

Verification
REQ-036 Fetch read: m[0x010]=0x12, m[0x011]=0x34, i_req addr 0x010 -> i_ack in cycle k+3, i_rdata=0x1234, mem_addr 0x010 then 0x011.
REQ-037 Data write: d_we=1, d_addr 0x020, d_wdata=0xBEEF -> m[0x020]=0xBE, m[0x021]=0xEF, d_ack at k+3, i_ack=0.
REQ-038 Contention: i_req and d_req both high continuously -> fixed mode all grants to data; MCU0_ARB_RR_EN alternates D,I,D,I every 4 cycles.
REQ-039 Wrap: d read at 0xFFF with m[0xFFF]=0xAA, m[0x000]=0x55 -> d_rdata=0xAA55.
REQ-040 Reset in LO of write 0x1234 at 0x030 -> no d_ack, m[0x030]=0x12, m[0x031] unchanged, busy=0 immediately, next request serviced normally.
